wb_port_arb: RTL and testbench

WB_PORT_ARB -- requirements
Module: wb_port_arb

---
 rtl/common_params.sv | 13 +
 rtl/wb_port_arb_if.sv | 43 ++++
 rtl/wb_cp_fifo.sv | 101 ++++++++++
 rtl/wb_port_arb.sv | 122 ++++++++++++
 tb/tb_wb_port_arb.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/common_params.sv
// Shared widths and the write-port grant encoding for the write-back arbiter.
package common_params;

    localparam int REG_ADDR_W = 5;
    localparam int BITS       = 32;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_PIPE = 2'd1,
        GRANT_CP   = 2'd2
    } wb_grant_t;

endpackage

// File: rtl/wb_port_arb_if.sv
// Bundle of pipeline, coprocessor, register-file and hazard signals around wb_port_arb.
// CP handshake: a result transfers on a rising edge where CP_VALID && CP_READY; CP_READY never depends on CP_VALID.
interface wb_port_arb_if;
    import common_params::*;

    logic                  PIPE_WE;
    logic [REG_ADDR_W-1:0] PIPE_RD;
    logic [BITS-1:0]       PIPE_DATA;

    logic                  CP_VALID;
    logic [REG_ADDR_W-1:0] CP_RD;
    logic [BITS-1:0]       CP_DATA;
    logic                  CP_READY;

    logic                  RF_WE;
    logic [REG_ADDR_W-1:0] RF_WADDR;
    logic [BITS-1:0]       RF_WDATA;
    wb_grant_t             GRANT_SRC;

    logic [REG_ADDR_W-1:0] CHK_ADDR1;
    logic [REG_ADDR_W-1:0] CHK_ADDR2;
    logic                  PEND_HIT;
    logic                  PIPE_STALL;

    modport slave (
        input  PIPE_WE, PIPE_RD, PIPE_DATA,
        input  CP_VALID, CP_RD, CP_DATA,
        output CP_READY,
        output RF_WE, RF_WADDR, RF_WDATA, GRANT_SRC,
        input  CHK_ADDR1, CHK_ADDR2,
        output PEND_HIT, PIPE_STALL
    );

    modport master (
        output PIPE_WE, PIPE_RD, PIPE_DATA,
        output CP_VALID, CP_RD, CP_DATA,
        input  CP_READY,
        input  RF_WE, RF_WADDR, RF_WDATA, GRANT_SRC,
        output CHK_ADDR1, CHK_ADDR2,
        input  PEND_HIT, PIPE_STALL
    );

endinterface

// File: rtl/wb_cp_fifo.sv
// Coprocessor result queue; each slot keeps a valid bit so entries can be squashed in place.
module wb_cp_fifo
    import common_params::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             push,
    input  logic [REG_ADDR_W-1:0]            push_rd,
    input  logic [BITS-1:0]                  push_data,
    input  logic                             pop,
    input  logic                             squash_en,
    input  logic [REG_ADDR_W-1:0]            squash_rd,
    output logic                             full,
    output logic                             empty,
    output logic                             head_valid,
    output logic [REG_ADDR_W-1:0]            head_rd,
    output logic [BITS-1:0]                  head_data,
    output logic [DEPTH-1:0]                 ent_valid,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0] ent_rd
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    logic [PTR_W-1:0]                 wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]                 rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic [DEPTH-1:0]                 vld_q, vld_d;
    logic [DEPTH-1:0][REG_ADDR_W-1:0] rd_q, rd_d;
    logic [DEPTH-1:0][BITS-1:0]       data_q, data_d;
    logic                             do_push, do_pop;

    assign full       = (cnt_q == CNT_W'(DEPTH));
    assign empty      = (cnt_q == '0);
    assign do_push    = push && !full;
    assign do_pop     = pop && !empty;
    assign head_valid = !empty && vld_q[rd_ptr_q];
    assign head_rd    = rd_q[rd_ptr_q];
    assign head_data  = data_q[rd_ptr_q];
    assign ent_valid  = vld_q;
    assign ent_rd     = rd_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        vld_d    = vld_q;
        rd_d     = rd_q;
        data_d   = data_q;

        // Squashed slots stay allocated until they reach the head and are dropped.
        if (squash_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (vld_q[i] && (rd_q[i] == squash_rd)) vld_d[i] = 1'b0;
            end
        end

        if (do_pop) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = ptr_inc(rd_ptr_q);
        end

        if (do_push) begin
            vld_d[wr_ptr_q]  = 1'b1;
            rd_d[wr_ptr_q]   = push_rd;
            data_d[wr_ptr_q] = push_data;
            wr_ptr_d         = ptr_inc(wr_ptr_q);
        end

        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            vld_q    <= '0;
            rd_q     <= '0;
            data_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            vld_q    <= vld_d;
            rd_q     <= rd_d;
            data_q   <= data_d;
        end
    end

endmodule

// File: rtl/wb_port_arb.sv
// Shares one register-file write port between the pipeline and queued coprocessor results.
// Define WB_ARB_STARVE_GUARD_EN to build the starvation counter that stalls the pipeline.
module wb_port_arb
    import common_params::*;
#(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    wb_port_arb_if.slave bus
);

    logic                                  fifo_full, fifo_empty, fifo_head_valid;
    logic [REG_ADDR_W-1:0]                 fifo_head_rd;
    logic [BITS-1:0]                       fifo_head_data;
    logic [FIFO_DEPTH-1:0]                 ent_valid;
    logic [FIFO_DEPTH-1:0][REG_ADDR_W-1:0] ent_rd;
    logic                                  cp_push, fifo_pop, pipe_eff, pipe_stall, pend_hit;
    logic                                  rf_we;
    logic [REG_ADDR_W-1:0]                 rf_waddr;
    logic [BITS-1:0]                       rf_wdata;
    wb_grant_t                             grant_src;

    // Ready comes from registered occupancy only; RD=0 results are accepted and dropped.
    assign cp_push  = bus.CP_VALID && !fifo_full && (bus.CP_RD != '0);
    assign pipe_eff = bus.PIPE_WE && (bus.PIPE_RD != '0) && !pipe_stall;

    always_comb begin
        grant_src = GRANT_NONE;
        rf_we     = 1'b0;
        rf_waddr  = '0;
        rf_wdata  = '0;
        if (pipe_stall && fifo_head_valid) begin
            grant_src = GRANT_CP;
        end else if (pipe_eff) begin
            grant_src = GRANT_PIPE;
        end else if (fifo_head_valid) begin
            grant_src = GRANT_CP;
        end
        if (grant_src == GRANT_PIPE) begin
            rf_we    = 1'b1;
            rf_waddr = bus.PIPE_RD;
            rf_wdata = bus.PIPE_DATA;
        end else if (grant_src == GRANT_CP) begin
            rf_we    = 1'b1;
            rf_waddr = fifo_head_rd;
            rf_wdata = fifo_head_data;
        end
    end

    // A squashed head is retired without a write so it cannot block the queue.
    assign fifo_pop = (grant_src == GRANT_CP) || (!fifo_empty && !fifo_head_valid);

    always_comb begin
        pend_hit = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (ent_valid[i] && (ent_rd[i] != '0) &&
                ((ent_rd[i] == bus.CHK_ADDR1) || (ent_rd[i] == bus.CHK_ADDR2)))
                pend_hit = 1'b1;
        end
    end

`ifdef WB_ARB_STARVE_GUARD_EN
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
    logic                pipe_stall_q, pipe_stall_d;

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (fifo_empty || fifo_pop)
            starve_cnt_d = '0;
        else if (starve_cnt_q != STARVE_W'(STARVE_LIMIT))
            starve_cnt_d = starve_cnt_q + STARVE_W'(1);
        pipe_stall_d = (starve_cnt_d == STARVE_W'(STARVE_LIMIT));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
            pipe_stall_q <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            pipe_stall_q <= pipe_stall_d;
        end
    end

    assign pipe_stall = pipe_stall_q;
`else
    assign pipe_stall = 1'b0;
`endif

    wb_cp_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (cp_push),
        .push_rd    (bus.CP_RD),
        .push_data  (bus.CP_DATA),
        .pop        (fifo_pop),
        .squash_en  (grant_src == GRANT_PIPE),
        .squash_rd  (bus.PIPE_RD),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .head_valid (fifo_head_valid),
        .head_rd    (fifo_head_rd),
        .head_data  (fifo_head_data),
        .ent_valid  (ent_valid),
        .ent_rd     (ent_rd)
    );

    assign bus.CP_READY   = !fifo_full;
    assign bus.RF_WE      = rf_we;
    assign bus.RF_WADDR   = rf_waddr;
    assign bus.RF_WDATA   = rf_wdata;
    assign bus.GRANT_SRC  = grant_src;
    assign bus.PEND_HIT   = pend_hit;
    assign bus.PIPE_STALL = pipe_stall;

endmodule

// File: tb/tb_wb_port_arb.sv
// Directed bench for wb_port_arb: inputs driven #1 after the rising edge, outputs sampled on the falling edge.
module tb_wb_port_arb;
    import common_params::*;

    localparam int W = 1 + REG_ADDR_W + BITS + 2;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_err;
    logic [W-1:0] exp_q[$];

    wb_port_arb_if bus ();

    wb_port_arb #(
        .FIFO_DEPTH   (2),
        .STARVE_LIMIT (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    task automatic chk1(input string tag, input logic obs, input logic expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    // Expected write-port tuple {we, waddr, wdata, grant} goes through the scoreboard queue.
    task automatic chk_rf(input string tag, input logic we, input logic [REG_ADDR_W-1:0] addr,
                          input logic [BITS-1:0] data, input wb_grant_t src);
        logic [W-1:0] obs;
        logic [W-1:0] expv;
        exp_q.push_back({we, addr, data, src});
        obs  = {bus.RF_WE, bus.RF_WADDR, bus.RF_WDATA, bus.GRANT_SRC};
        expv = exp_q.pop_front();
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic drive_pipe(input logic we, input logic [REG_ADDR_W-1:0] rd, input logic [BITS-1:0] data);
        bus.PIPE_WE   = we;
        bus.PIPE_RD   = rd;
        bus.PIPE_DATA = data;
    endtask

    task automatic drive_cp(input logic vld, input logic [REG_ADDR_W-1:0] rd, input logic [BITS-1:0] data);
        bus.CP_VALID = vld;
        bus.CP_RD    = rd;
        bus.CP_DATA  = data;
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        drive_pipe(1'b0, 5'd0, 32'h0);
        drive_cp(1'b0, 5'd0, 32'h0);
        bus.CHK_ADDR1 = 5'd0;
        bus.CHK_ADDR2 = 5'd0;

        // Reset values
        repeat (2) @(posedge clk);
        look();
        chk_rf("reset_rf", 1'b0, 5'd0, 32'h0, GRANT_NONE);
        chk1("reset_cp_ready", bus.CP_READY, 1'b1);
        chk1("reset_stall", bus.PIPE_STALL, 1'b0);
        chk1("reset_pend", bus.PEND_HIT, 1'b0);
        next_cycle();
        rst_n = 1'b1;

        // Pipeline-only write, same cycle
        drive_pipe(1'b1, 5'd5, 32'hDEADBEEF);
        look();
        chk_rf("pipe_only", 1'b1, 5'd5, 32'hDEADBEEF, GRANT_PIPE);
        next_cycle();
        drive_pipe(1'b1, 5'd0, 32'h12345678);
        look();
        chk_rf("pipe_rd0", 1'b0, 5'd0, 32'h0, GRANT_NONE);
        next_cycle();

        // Coprocessor drain with idle pipeline
        drive_pipe(1'b0, 5'd0, 32'h0);
        drive_cp(1'b1, 5'd7, 32'h1234);
        look();
        chk1("cp_ready_idle", bus.CP_READY, 1'b1);
        chk_rf("cp_no_bypass", 1'b0, 5'd0, 32'h0, GRANT_NONE);
        next_cycle();
        drive_cp(1'b0, 5'd0, 32'h0);
        bus.CHK_ADDR2 = 5'd7;
        look();
        chk_rf("cp_drain", 1'b1, 5'd7, 32'h1234, GRANT_CP);
        chk1("cp_pend_hit2", bus.PEND_HIT, 1'b1);
        next_cycle();
        look();
        chk_rf("cp_drained", 1'b0, 5'd0, 32'h0, GRANT_NONE);
        chk1("cp_pend_clear", bus.PEND_HIT, 1'b0);
        next_cycle();
        bus.CHK_ADDR2 = 5'd0;

        // Full queue while the pipeline writes every cycle
        drive_pipe(1'b1, 5'd9, 32'h900);
        drive_cp(1'b1, 5'd10, 32'hA1);
        look();
        chk_rf("full_pipe_a", 1'b1, 5'd9, 32'h900, GRANT_PIPE);
        next_cycle();
        drive_pipe(1'b1, 5'd9, 32'h901);
        drive_cp(1'b1, 5'd11, 32'hB2);
        look();
        chk1("full_ready_b", bus.CP_READY, 1'b1);
        next_cycle();
        drive_pipe(1'b1, 5'd9, 32'h902);
        drive_cp(1'b1, 5'd12, 32'hC3);
        look();
        chk1("full_ready_c", bus.CP_READY, 1'b0);
        chk_rf("full_pipe_c", 1'b1, 5'd9, 32'h902, GRANT_PIPE);
        next_cycle();
        drive_pipe(1'b0, 5'd0, 32'h0);
        look();
        chk1("full_pop_cycle_ready", bus.CP_READY, 1'b0);
        chk_rf("full_drain_a", 1'b1, 5'd10, 32'hA1, GRANT_CP);
        next_cycle();
        look();
        chk1("full_after_pop_ready", bus.CP_READY, 1'b1);
        chk_rf("full_drain_b", 1'b1, 5'd11, 32'hB2, GRANT_CP);
        next_cycle();
        drive_cp(1'b0, 5'd0, 32'h0);
        look();
        chk_rf("full_drain_c", 1'b1, 5'd12, 32'hC3, GRANT_CP);
        next_cycle();
        look();
        chk_rf("full_empty", 1'b0, 5'd0, 32'h0, GRANT_NONE);
        next_cycle();

        // Squash: queued RD=3 overwritten by the pipeline
        drive_pipe(1'b1, 5'd8, 32'h800);
        drive_cp(1'b1, 5'd3, 32'h55);
        next_cycle();
        drive_cp(1'b0, 5'd0, 32'h0);
        drive_pipe(1'b1, 5'd3, 32'hAA);
        bus.CHK_ADDR1 = 5'd3;
        look();
        chk1("squash_pend_before", bus.PEND_HIT, 1'b1);
        chk_rf("squash_pipe", 1'b1, 5'd3, 32'hAA, GRANT_PIPE);
        next_cycle();
        drive_pipe(1'b0, 5'd0, 32'h0);
        look();
        chk1("squash_pend_after", bus.PEND_HIT, 1'b0);
        chk_rf("squash_no_write", 1'b0, 5'd0, 32'h0, GRANT_NONE);
        next_cycle();
        look();
        chk_rf("squash_no_write2", 1'b0, 5'd0, 32'h0, GRANT_NONE);
        chk1("squash_ready", bus.CP_READY, 1'b1);
        next_cycle();
        bus.CHK_ADDR1 = 5'd0;

        // RD=0 result is accepted but never written
        drive_cp(1'b1, 5'd0, 32'hFF);
        look();
        chk1("rd0_ready", bus.CP_READY, 1'b1);
        next_cycle();
        drive_cp(1'b0, 5'd0, 32'h0);
        look();
        chk_rf("rd0_discard", 1'b0, 5'd0, 32'h0, GRANT_NONE);
        next_cycle();

        // Starvation: one entry waiting behind a continuously writing pipeline
        drive_pipe(1'b1, 5'd6, 32'h600);
        drive_cp(1'b1, 5'd4, 32'h77);
        next_cycle();
        drive_cp(1'b0, 5'd0, 32'h0);
`ifdef WB_ARB_STARVE_GUARD_EN
        for (int k = 1; k <= 8; k++) begin
            look();
            chk1("starve_wait_stall", bus.PIPE_STALL, 1'b0);
            chk_rf("starve_wait_pipe", 1'b1, 5'd6, 32'h600, GRANT_PIPE);
            next_cycle();
        end
        look();
        chk1("starve_stall", bus.PIPE_STALL, 1'b1);
        chk_rf("starve_cp", 1'b1, 5'd4, 32'h77, GRANT_CP);
        next_cycle();
        look();
        chk1("starve_stall_drop", bus.PIPE_STALL, 1'b0);
        chk_rf("starve_pipe_resume", 1'b1, 5'd6, 32'h600, GRANT_PIPE);
        next_cycle();
        drive_pipe(1'b0, 5'd0, 32'h0);
`else
        for (int k = 1; k <= 10; k++) begin
            look();
            chk1("noguard_stall", bus.PIPE_STALL, 1'b0);
            chk_rf("noguard_pipe", 1'b1, 5'd6, 32'h600, GRANT_PIPE);
            next_cycle();
        end
        drive_pipe(1'b0, 5'd0, 32'h0);
        look();
        chk_rf("noguard_drain", 1'b1, 5'd4, 32'h77, GRANT_CP);
        next_cycle();
`endif
        look();
        chk_rf("starve_idle", 1'b0, 5'd0, 32'h0, GRANT_NONE);
        next_cycle();

        // Reset mid-operation with two queued entries
        drive_pipe(1'b1, 5'd6, 32'h610);
        drive_cp(1'b1, 5'd13, 32'hD1);
        next_cycle();
        drive_cp(1'b1, 5'd14, 32'hE2);
        next_cycle();
        drive_cp(1'b0, 5'd0, 32'h0);
        bus.CHK_ADDR1 = 5'd13;
        look();
        chk1("rst_pre_full", bus.CP_READY, 1'b0);
        chk1("rst_pre_pend", bus.PEND_HIT, 1'b1);
        drive_pipe(1'b0, 5'd0, 32'h0);
        rst_n = 1'b0;
        #1;
        chk1("rst_async_ready", bus.CP_READY, 1'b1);
        chk_rf("rst_async_rf", 1'b0, 5'd0, 32'h0, GRANT_NONE);
        next_cycle();
        rst_n = 1'b1;
        look();
        chk1("rst_post_ready", bus.CP_READY, 1'b1);
        chk1("rst_post_pend", bus.PEND_HIT, 1'b0);
        chk_rf("rst_post_rf", 1'b0, 5'd0, 32'h0, GRANT_NONE);
        next_cycle();
        look();
        chk_rf("rst_post_rf2", 1'b0, 5'd0, 32'h0, GRANT_NONE);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
